// File: rtl/mac_led_pkg.sv
// mac_led_pkg
//   Shared definitions for the MAC serial LED stream decoder.
//   - state_t    : frame decoder states (IDLE/START/SHIFT/DRAIN)
//   - frame_bits : total bits in one frame (ports x bits per port)
//   - sat_inc    : saturating increment for counters up to 32 bits wide
package mac_led_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SHIFT = 2'd2,
    DRAIN = 2'd3
  } state_t;

  function automatic int frame_bits(input int num_ports, input int bits_per_port);
    return num_ports * bits_per_port;
  endfunction

  // Increments value but sticks at the all-ones pattern of a width-bit counter.
  // Callers zero-extend their counter into 32 bits and truncate the result back.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value == max_val) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/mac_led_sync_edge.sv
// mac_led_sync_edge
//   Brings one asynchronous line into the clk domain through SYNC_STAGES
//   flops, then one more flop used only for edge detection.
// Ports
//   clk    in  1  sampling clock
//   rst_n  in  1  asynchronous reset, active low
//   din    in  1  asynchronous input line
//   level  out 1  synchronised level
//   rise   out 1  one-cycle pulse on a synchronised 0->1 transition
//   fall   out 1  one-cycle pulse on a synchronised 1->0 transition
module mac_led_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   edge_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
      edge_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
      edge_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign level = sync_reg[SYNC_STAGES-1];
  assign rise  = level & ~edge_reg;
  assign fall  = ~level & edge_reg;

endmodule

// File: rtl/mac_led_stream_decoder.sv
// mac_led_stream_decoder
//   Decodes the MAC serial LED stream (start pulse on LED_DATA0 while
//   LED_CLK0 is low, then NUM_PORTS*BITS_PER_PORT bits sampled on LED_CLK0
//   rising edges) into a parallel LED word, with frame error detection,
//   saturating counters and a stale-link watchdog.
// Ports
//   iClk          in  1           system clock
//   iRstn         in  1           asynchronous reset, active low
//   LED_CLK0      in  1           serial LED clock (async)
//   LED_DATA0     in  1           serial LED data (async)
//   oLed_data     out FRAME_BITS  last good frame, port 0 in the top bits
//   oFrame_valid  out 1           pulse when oLed_data is updated
//   oFrame_err    out 1           pulse on short frame, overrun or missing start
//   oStale        out 1           no good frame for FRAME_WDOG cycles
//   oFrame_cnt    out CNT_W       good frames (saturating)
//   oErr_cnt      out CNT_W       errored frames (saturating)
module mac_led_stream_decoder
  import mac_led_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int BITS_PER_PORT  = 16,
  parameter bit LSB_FIRST      = 1'b0,
  parameter int SYNC_STAGES    = 2,
  parameter int IDLE_TIMEOUT   = 64,
  parameter int FRAME_WDOG     = 1000000,
  parameter bit CLEAR_ON_STALE = 1'b0,
  parameter int CNT_W          = 16,
  localparam int FRAME_BITS    = frame_bits(NUM_PORTS, BITS_PER_PORT)
) (
  input  logic                  iClk,
  input  logic                  iRstn,
  input  logic                  LED_CLK0,
  input  logic                  LED_DATA0,
  output logic [FRAME_BITS-1:0] oLed_data,
  output logic                  oFrame_valid,
  output logic                  oFrame_err,
  output logic                  oStale,
  output logic [CNT_W-1:0]      oFrame_cnt,
  output logic [CNT_W-1:0]      oErr_cnt
);

  localparam int BIT_W  = $clog2(FRAME_BITS + 1);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam int WDOG_W = $clog2(FRAME_WDOG + 1);

  logic clk_s, clk_rise, clk_fall_unused;
  logic data_s, data_rise, data_fall;

  // Both lines go through identical pipelines so their edges stay aligned.
  mac_led_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk   (iClk),
    .rst_n (iRstn),
    .din   (LED_CLK0),
    .level (clk_s),
    .rise  (clk_rise),
    .fall  (clk_fall_unused)
  );

  mac_led_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
    .clk   (iClk),
    .rst_n (iRstn),
    .din   (LED_DATA0),
    .level (data_s),
    .rise  (data_rise),
    .fall  (data_fall)
  );

  state_t                 state_reg;
  logic [FRAME_BITS-1:0]  shift_reg;
  logic [FRAME_BITS-1:0]  shift_next;
  logic [FRAME_BITS-1:0]  led_data_reg;
  logic [BIT_W-1:0]       bit_cnt_reg;
  logic [IDLE_W-1:0]      idle_cnt_reg;
  logic [WDOG_W-1:0]      wdog_cnt_reg;
  logic [CNT_W-1:0]       frame_cnt_reg;
  logic [CNT_W-1:0]       err_cnt_reg;
  logic                   valid_reg;
  logic                   err_reg;
  logic                   stale_reg;
  logic                   err_flagged_reg;  // error already reported for this frame
  logic                   commit;
  logic                   idle_expired;

  // With MSB-first the first received bit ends up at the top after FRAME_BITS shifts.
  assign shift_next = LSB_FIRST ? {data_s, shift_reg[FRAME_BITS-1:1]}
                                : {shift_reg[FRAME_BITS-2:0], data_s};

  assign commit       = (state_reg == SHIFT) && clk_rise &&
                        (bit_cnt_reg == BIT_W'(FRAME_BITS - 1));
  // idle_cnt_reg counts quiet cycles already elapsed; this cycle is the last one.
  assign idle_expired = (idle_cnt_reg == IDLE_W'(IDLE_TIMEOUT - 1));

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state_reg       <= IDLE;
      shift_reg       <= '0;
      led_data_reg    <= '0;
      bit_cnt_reg     <= '0;
      idle_cnt_reg    <= '0;
      wdog_cnt_reg    <= '0;
      frame_cnt_reg   <= '0;
      err_cnt_reg     <= '0;
      valid_reg       <= 1'b0;
      err_reg         <= 1'b0;
      stale_reg       <= 1'b0;
      err_flagged_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;

      case (state_reg)
        IDLE: begin
          idle_cnt_reg    <= '0;
          err_flagged_reg <= 1'b0;
          if (data_rise && !clk_s) begin
            state_reg <= START;
          end else if (clk_rise) begin
            // Clocking without a start pulse: report once, then drain the rest.
            state_reg       <= DRAIN;
            err_reg         <= 1'b1;
            err_cnt_reg     <= CNT_W'(sat_inc(32'(err_cnt_reg), CNT_W));
            err_flagged_reg <= 1'b1;
          end
        end

        START: begin
          if (data_fall) begin
            state_reg    <= SHIFT;
            bit_cnt_reg  <= '0;
            idle_cnt_reg <= '0;
          end else if (idle_expired) begin
            state_reg   <= IDLE;
            err_reg     <= 1'b1;
            err_cnt_reg <= CNT_W'(sat_inc(32'(err_cnt_reg), CNT_W));
          end else begin
            idle_cnt_reg <= idle_cnt_reg + 1'b1;
          end
        end

        SHIFT: begin
          if (clk_rise) begin
            shift_reg    <= shift_next;
            bit_cnt_reg  <= bit_cnt_reg + 1'b1;
            idle_cnt_reg <= '0;
            if (commit) begin
              led_data_reg    <= shift_next;
              valid_reg       <= 1'b1;
              frame_cnt_reg   <= CNT_W'(sat_inc(32'(frame_cnt_reg), CNT_W));
              err_flagged_reg <= 1'b0;
              state_reg       <= DRAIN;
            end
          end else if (idle_expired) begin
            // Short frame: drop it and keep the previously committed data.
            state_reg   <= IDLE;
            err_reg     <= 1'b1;
            err_cnt_reg <= CNT_W'(sat_inc(32'(err_cnt_reg), CNT_W));
          end else begin
            idle_cnt_reg <= idle_cnt_reg + 1'b1;
          end
        end

        DRAIN: begin
          if (clk_rise) begin
            idle_cnt_reg <= '0;
            if (!err_flagged_reg) begin
              err_reg         <= 1'b1;
              err_cnt_reg     <= CNT_W'(sat_inc(32'(err_cnt_reg), CNT_W));
              err_flagged_reg <= 1'b1;
            end
          end else if (idle_expired) begin
            state_reg <= IDLE;
          end else begin
            idle_cnt_reg <= idle_cnt_reg + 1'b1;
          end
        end

        default: state_reg <= IDLE;
      endcase

      // Watchdog: a commit and a stale-clear never happen in the same cycle,
      // so the two writes to led_data_reg are exclusive.
      if (commit) begin
        wdog_cnt_reg <= '0;
        stale_reg    <= 1'b0;
      end else if (wdog_cnt_reg != WDOG_W'(FRAME_WDOG)) begin
        wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
        if (wdog_cnt_reg == WDOG_W'(FRAME_WDOG - 1)) begin
          stale_reg <= 1'b1;
          if (CLEAR_ON_STALE) begin
            led_data_reg <= '0;
          end
        end
      end
    end
  end

  assign oLed_data    = led_data_reg;
  assign oFrame_valid = valid_reg;
  assign oFrame_err   = err_reg;
  assign oStale       = stale_reg;
  assign oFrame_cnt   = frame_cnt_reg;
  assign oErr_cnt     = err_cnt_reg;

endmodule
